vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width and back porch in pixels.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync width and back porch in lines.
REQ-005 Parameter CW, 10, counter width; must hold the horizontal total minus 1 and the vertical total minus 1.
REQ-006 Parameter HSYNC_POL / VSYNC_POL, 0 / 0, asserted sync level (0 = active-low).
REQ-007 clk  input  1  pixel-rate clock.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 ce  input  1  pixel clock enable; all state advances only on clk edges with ce=1.
REQ-010 run  input  1  request to generate frames.
REQ-011 hsync, vsync  output  1  sync pulses at the configured polarity.
REQ-012 de  output  1  display enable (visible region).
REQ-013 horiz_count, vert_count  output  CW  current pixel/line position.
REQ-014 line_start, frame_start  output  1  one-ce-cycle strobes at horiz_count=0 and at (0,0) respectively.
REQ-015 busy  output  1  high in RUN or DRAIN.

Function
REQ-016 HT = H_ACTIVE+H_FP+H_SYNC+H_BP and VT = V_ACTIVE+V_FP+V_SYNC+V_BP; horiz_count spans 0..HT-1 and vert_count spans 0..VT-1.
REQ-017 On ce in RUN/DRAIN, horiz_count increments and wraps from HT-1 to 0; vert_count increments only on that wrap and wraps from VT-1 to 0.
REQ-018 hsync is asserted iff H_ACTIVE+H_FP <= horiz_count < H_ACTIVE+H_FP+H_SYNC; with defaults that is counts 656..751.
REQ-019 vsync is asserted iff V_ACTIVE+V_FP <= vert_count < V_ACTIVE+V_FP+V_SYNC; with defaults that is lines 490..491.
REQ-020 de=1 iff horiz_count<H_ACTIVE and vert_count<V_ACTIVE, and the state is RUN or DRAIN.
REQ-021 The block has three states:
- IDLE: counters held at 0; syncs deasserted; de=0; strobes=0.
- IDLE->RUN when run=1 and ce=1; the first RUN cycle is at (0,0) with frame_start=1.
- RUN->DRAIN when run=0.
- DRAIN->RUN when run returns to 1 before the frame ends (no glitch, no restart).
- DRAIN->IDLE at the ce where the (HT-1, VT-1) wrap occurs; a frame is never truncated.
REQ-022 If run=0 at the final pixel while in RUN, the block enters IDLE directly at the wrap.
REQ-023 When ce=0, all outputs and state hold; strobes remain asserted only while their position holds.
REQ-024 All outputs are registered; position and sync, de and strobe outputs are mutually consistent in the same cycle.

Reset
REQ-025 While reset=1: state=IDLE, horiz_count=0, vert_count=0, hsync=vsync=deasserted level, de=0, line_start=0, frame_start=0, busy=0.
REQ-026 Reset asserted mid-frame takes effect immediately (asynchronously); after release the block waits for run=1 as in IDLE.

Configuration
REQ-027 Macro VGA_TIMING_PIPE_EN: when defined, hsync, vsync, de, line_start and frame_start are additionally delayed by exactly 2 ce-qualified stages; horiz_count and vert_count are not delayed. This aligns the signals with a 2-stage pixel generator. When undefined, no extra delay is added (REQ-024 timing).
REQ-028 With VGA_TIMING_PIPE_EN, the delay pipeline clears on reset and flushes to deasserted values in IDLE.

Verification
REQ-029 Defaults, run=1, ce=1: hsync asserted exactly at horiz_count 656..751 (96 clocks), and line period = 800 clocks.
REQ-030 Defaults, run held 1: vsync asserted on lines 490-491 only; frame_start period = 420000 clocks; de high for 307200 clocks per frame.
REQ-031 ce toggling 1/0 every cycle: all periods double (line = 1600 clk); outputs hold during ce=0 cycles.
REQ-032 run dropped at (100,200): frame continues to (799,524); busy falls and counters sit at 0. run raised again at (300,400) during DRAIN: no discontinuity.
REQ-033 reset pulsed at (400,300): all outputs take reset values within the cycle. After release with run=1, first frame_start at (0,0).
REQ-034 Build with VGA_TIMING_PIPE_EN and H_ACTIVE=800, HSYNC_POL=1: hsync high at counts 818..913 (pulse placed at 816..911, delayed 2 clocks relative to count).

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//    Raster timing generator for VGA-style displays. It produces horizontal
//    and vertical position counters, sync pulses at a configurable polarity,
//    a display-enable flag for the visible region, and line/frame start
//    strobes. Frame generation is requested with run. When run is dropped,
//    the current frame is always completed before the block goes idle.
//
// Optional build macro:
//    VGA_TIMING_PIPE_EN - when defined, hsync, vsync, de, line_start and
//                         frame_start are delayed by two extra ce-qualified
//                         register stages. This lines them up with a
//                         two-stage pixel pipeline. horiz_count and
//                         vert_count are never delayed.
//
// Ports:
//    clk          in   pixel-rate clock
//    reset        in   asynchronous, active-high reset
//    ce           in   pixel clock enable; all state advances only when ce=1
//    run          in   request to generate frames
//    hsync        out  horizontal sync at HSYNC_POL
//    vsync        out  vertical sync at VSYNC_POL
//    de           out  display enable (visible pixel)
//    horiz_count  out  current pixel position within the line (CW bits)
//    vert_count   out  current line position within the frame (CW bits)
//    line_start   out  strobe while horiz_count == 0
//    frame_start  out  strobe while position == (0,0)
//    busy         out  high while a frame is in progress (RUN or DRAIN)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   // CW must be wide enough to hold HT-1 and VT-1
   parameter int unsigned CW        = 10,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce,
   input  logic          run,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] horiz_count,
   output logic [CW-1:0] vert_count,
   output logic          line_start,
   output logic          frame_start,
   output logic          busy
);

   localparam int unsigned HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
   localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
   localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [CW-1:0] r_h;
   logic [CW-1:0] r_v;
   logic [CW-1:0] w_h_nxt;
   logic [CW-1:0] w_v_nxt;

   logic          w_h_last;
   logic          w_v_last;
   logic          w_frame_end;

   logic          w_busy_nxt;
   logic          w_hs_act;
   logic          w_vs_act;
   logic          w_de_nxt;
   logic          w_ls_nxt;
   logic          w_fs_nxt;

   logic          r_hs;
   logic          r_vs;
   logic          r_de;
   logic          r_ls;
   logic          r_fs;
   logic          r_busy;

   assign w_h_last    = (r_h == CW'(HT - 1));
   assign w_v_last    = (r_v == CW'(VT - 1));
   assign w_frame_end = w_h_last && w_v_last;

   // -----------------------------------------------------------------------
   // Next-state and next-position logic
   // -----------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h;
      w_v_nxt     = r_v;

      unique case (r_state)
         S_IDLE: begin
            w_h_nxt = '0;
            w_v_nxt = '0;
            if (run) begin
               w_state_nxt = S_RUN;
            end
         end

         S_RUN, S_DRAIN: begin
            if (w_h_last) begin
               w_h_nxt = '0;
               w_v_nxt = w_v_last ? '0 : (r_v + CW'(1));
            end else begin
               w_h_nxt = r_h + CW'(1);
            end

            // Going idle is only possible at the final pixel of a frame.
            // RUN with run=0 on the final pixel goes straight to IDLE.
            // A raised run in DRAIN resumes RUN without touching the counters.
            if (w_frame_end && !run) begin
               w_state_nxt = S_IDLE;
            end else if (run) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_DRAIN;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_h_nxt     = '0;
            w_v_nxt     = '0;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Output decode on the next position. Decoding here, then registering
   // together with the counters, keeps all outputs consistent in the
   // same cycle.
   // -----------------------------------------------------------------------
   always_comb begin
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_hs_act   = w_busy_nxt &&
                   (w_h_nxt >= CW'(HS_BEG)) && (w_h_nxt < CW'(HS_END));
      w_vs_act   = w_busy_nxt &&
                   (w_v_nxt >= CW'(VS_BEG)) && (w_v_nxt < CW'(VS_END));
      w_de_nxt   = w_busy_nxt &&
                   (w_h_nxt < CW'(H_ACTIVE)) && (w_v_nxt < CW'(V_ACTIVE));
      w_ls_nxt   = w_busy_nxt && (w_h_nxt == '0);
      w_fs_nxt   = w_busy_nxt && (w_h_nxt == '0) && (w_v_nxt == '0);
   end

   // -----------------------------------------------------------------------
   // State, counters and undelayed outputs
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_h     <= '0;
         r_v     <= '0;
         r_hs    <= ~HSYNC_POL;
         r_vs    <= ~VSYNC_POL;
         r_de    <= 1'b0;
         r_ls    <= 1'b0;
         r_fs    <= 1'b0;
         r_busy  <= 1'b0;
      end else if (ce) begin
         r_state <= w_state_nxt;
         r_h     <= w_h_nxt;
         r_v     <= w_v_nxt;
         r_hs    <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
         r_vs    <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
         r_de    <= w_de_nxt;
         r_ls    <= w_ls_nxt;
         r_fs    <= w_fs_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign horiz_count = r_h;
   assign vert_count  = r_v;
   assign busy        = r_busy;

`ifdef VGA_TIMING_PIPE_EN
   // Bit order: {hsync, vsync, de, line_start, frame_start}.
   // In IDLE the stage inputs are already at deasserted levels, so the
   // pipe drains to idle values after two ce cycles.
   localparam logic [4:0] PIPE_IDLE = {~HSYNC_POL, ~VSYNC_POL, 3'b000};

   logic [4:0] r_pipe1;
   logic [4:0] r_pipe2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pipe1 <= PIPE_IDLE;
         r_pipe2 <= PIPE_IDLE;
      end else if (ce) begin
         r_pipe1 <= {r_hs, r_vs, r_de, r_ls, r_fs};
         r_pipe2 <= r_pipe1;
      end
   end

   assign {hsync, vsync, de, line_start, frame_start} = r_pipe2;
`else
   assign hsync       = r_hs;
   assign vsync       = r_vs;
   assign de          = r_de;
   assign line_start  = r_ls;
   assign frame_start = r_fs;
`endif

endmodule
